// File: rtl/mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | mem_responder: tagged split-transaction memory target with a fixed  |
// | load latency and a 15-entry tag pool.                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_responder #(
  parameter int LATENCY   = 8,
  parameter int MEM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  proc2mem_command_i,
  input  logic [63:0] proc2mem_addr_i,
  input  logic [63:0] proc2mem_data_i,
  output logic [3:0]  mem2proc_response_o,
  output logic [3:0]  mem2proc_tag_o,
  output logic [63:0] mem2proc_data_o
);

  localparam int         c_IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [1:0] c_BUS_LOAD  = 2'd1;
  localparam logic [1:0] c_BUS_STORE = 2'd2;
  localparam logic [7:0] c_CNT_INIT  = 8'(LATENCY - 1);

  logic [15:1]        r_busy;
  logic [c_IDX_W-1:0] r_idx [1:15];
  logic [7:0]         r_cnt [1:15];
  logic [63:0]        r_mem [0:MEM_DEPTH-1];
  logic [3:0]         r_tag;
  logic [63:0]        r_data;

  logic               w_is_load;
  logic               w_is_store;
  logic               w_accept;
  logic [3:0]         w_free_tag;
  logic [3:0]         w_ready_tag;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_unused_addr;

  assign w_is_load     = (proc2mem_command_i == c_BUS_LOAD);
  assign w_is_store    = (proc2mem_command_i == c_BUS_STORE);
  assign w_idx         = proc2mem_addr_i[3 +: c_IDX_W];
  assign w_unused_addr = ^{proc2mem_addr_i[63:3+c_IDX_W], proc2mem_addr_i[2:0]};

  // Both searches look only at registered state, so a free slot and a ready
  // slot can never be the same tag.
  always_comb begin
    w_free_tag  = 4'd0;
    w_ready_tag = 4'd0;
    for (int i = 15; i >= 1; i--) begin
      if (!r_busy[i]) w_free_tag = 4'(i);
      if (r_busy[i] && (r_cnt[i] == 8'd0)) w_ready_tag = 4'(i);
    end
  end

  assign w_accept            = rst_n && (w_is_load || w_is_store) && (w_free_tag != 4'd0);
  assign mem2proc_response_o = w_accept ? w_free_tag : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int i = 1; i <= 15; i++) begin
        r_idx[i] <= '0;
        r_cnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 1; i <= 15; i++) begin
        if (w_ready_tag == 4'(i)) begin
          r_busy[i] <= 1'b0;
        end else if (w_accept && w_is_load && (w_free_tag == 4'(i))) begin
          r_busy[i] <= 1'b1;
          r_idx[i]  <= w_idx;
          r_cnt[i]  <= c_CNT_INIT;
        end else if (r_busy[i] && (r_cnt[i] != 8'd0)) begin
          r_cnt[i] <= r_cnt[i] - 8'd1;
        end
      end
    end
  end

  // Completion reads the array before any same-edge store lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag  <= 4'd0;
      r_data <= 64'd0;
    end else begin
      r_tag <= w_ready_tag;
      if (w_ready_tag != 4'd0) r_data <= r_mem[r_idx[w_ready_tag]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_is_store) r_mem[w_idx] <= proc2mem_data_i;
  end

  assign mem2proc_tag_o  = r_tag;
  assign mem2proc_data_o = r_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_mem_responder: directed stimulus with a completion scoreboard.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_responder;

  localparam int         c_LAT   = 40;
  localparam int         c_DEPTH = 256;
  localparam logic [1:0] c_NONE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_STORE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [63:0] addr = 64'd0;
  logic [63:0] wdata = 64'd0;
  logic [3:0]  response;
  logic [3:0]  tag;
  logic [63:0] rdata;

  typedef struct {
    int          edge_no;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_responder #(.LATENCY(c_LAT), .MEM_DEPTH(c_DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .proc2mem_command_i  (cmd),
    .proc2mem_addr_i     (addr),
    .proc2mem_data_i     (wdata),
    .mem2proc_response_o (response),
    .mem2proc_tag_o      (tag),
    .mem2proc_data_o     (rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: every nonzero completion tag must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && tag != 4'd0) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cpl: got tag %0d expected none (edge %0d)", tag, edge_cnt);
      end else begin
        e = q.pop_front();
        check("cpl_tag", 64'(tag), 64'(e.tag));
        check("cpl_data", rdata, e.data);
        check("cpl_edge", 64'(edge_cnt), 64'(e.edge_no));
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d,
                       input logic [3:0] exp_resp, input logic [63:0] exp_data);
    exp_t x;
    @(negedge clk);
    cmd = c;
    addr = a;
    wdata = d;
    #1;
    check("response", 64'(response), 64'(exp_resp));
    if (c == c_LOAD && exp_resp != 4'd0) begin
      x.edge_no = edge_cnt + 1 + c_LAT;
      x.tag = exp_resp;
      x.data = exp_data;
      q.push_back(x);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cmd = c_NONE;
      @(posedge clk);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    cmd = c_NONE;
    for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a load presented during reset.
    #1 cmd = c_LOAD;
    #1;
    check("rst_response", 64'(response), 64'd0);
    check("rst_tag", 64'(tag), 64'd0);
    check("rst_data", rdata, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmd = c_NONE;

    // Store then load.
    issue(c_STORE, 64'h40, 64'hDEAD_BEEF_0123_4567, 4'd1, 64'd0);
    issue(c_LOAD, 64'h40, 64'd0, 4'd1, 64'hDEAD_BEEF_0123_4567);
    drain();

    // Back-to-back loads.
    issue(c_STORE, 64'h100, 64'h0000_0000_0000_0100, 4'd1, 64'd0);
    issue(c_STORE, 64'h108, 64'h0000_0000_0000_0108, 4'd1, 64'd0);
    issue(c_STORE, 64'h110, 64'h0000_0000_0000_0110, 4'd1, 64'd0);
    issue(c_STORE, 64'h118, 64'h0000_0000_0000_0118, 4'd1, 64'd0);
    issue(c_LOAD, 64'h100, 64'd0, 4'd1, 64'h0000_0000_0000_0100);
    issue(c_LOAD, 64'h108, 64'd0, 4'd2, 64'h0000_0000_0000_0108);
    issue(c_LOAD, 64'h110, 64'd0, 4'd3, 64'h0000_0000_0000_0110);
    issue(c_LOAD, 64'h118, 64'd0, 4'd4, 64'h0000_0000_0000_0118);
    drain();

    // Full pool: 15 accepted, 16th retried until tag 1 frees up.
    for (int i = 0; i < 16; i++)
      issue(c_STORE, 64'h400 + 64'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i), 4'd1, 64'd0);
    for (int i = 0; i < 15; i++)
      issue(c_LOAD, 64'h400 + 64'(i * 8), 64'd0, 4'(i + 1), 64'hA5A5_0000_0000_0000 | 64'(i));
    for (int i = 15; i <= c_LAT; i++)
      issue(c_LOAD, 64'h478, 64'd0, 4'd0, 64'd0);
    issue(c_LOAD, 64'h478, 64'd0, 4'd1, 64'hA5A5_0000_0000_000F);
    drain();

    // Address wrap.
    issue(c_STORE, 64'h8, 64'h1111_2222_3333_4444, 4'd1, 64'd0);
    issue(c_STORE, 64'h8 + 64'(8 * c_DEPTH), 64'hBBBB_0000_CCCC_0001, 4'd1, 64'd0);
    issue(c_LOAD, 64'h8, 64'd0, 4'd1, 64'hBBBB_0000_CCCC_0001);
    issue(c_LOAD, 64'hF, 64'd0, 4'd2, 64'hBBBB_0000_CCCC_0001);
    drain();

    // Store accepted on the same edge the load completes.
    issue(c_STORE, 64'h200, 64'h0000_0000_00AA_0001, 4'd1, 64'd0);
    issue(c_LOAD, 64'h200, 64'd0, 4'd1, 64'h0000_0000_00AA_0001);
    idle(c_LAT - 1);
    issue(c_STORE, 64'h200, 64'h0000_0000_00BB_0002, 4'd2, 64'd0);
    drain();
    issue(c_LOAD, 64'h200, 64'd0, 4'd1, 64'h0000_0000_00BB_0002);
    drain();

    // Asynchronous reset with three loads outstanding.
    issue(c_LOAD, 64'h100, 64'd0, 4'd1, 64'd0);
    issue(c_LOAD, 64'h108, 64'd0, 4'd2, 64'd0);
    issue(c_LOAD, 64'h110, 64'd0, 4'd3, 64'd0);
    idle(2);
    @(negedge clk);
    #2;
    cmd = c_LOAD;
    addr = 64'h40;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_tag", 64'(tag), 64'd0);
    check("arst_data", rdata, 64'd0);
    check("arst_response", 64'(response), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmd = c_NONE;
    idle(c_LAT + 5);
    issue(c_LOAD, 64'h40, 64'd0, 4'd1, 64'hDEAD_BEEF_0123_4567);
    drain();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
